matrix_mac_engine: RTL and testbench

MATRIX_MAC_ENGINE -- requirements
Module: matrix_mac_engine

---
 rtl/matrix_mac_engine.sv | 148 ++++++++++++++
 tb/tb_matrix_mac_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mac_engine.sv
// 3x3 matrix multiply C = W x X over nine accumulators, streamed out one element per handshake.
// Optional MAC_SIGNED_EN: treat operands as 4-bit two's complement and accumulate signed.
module matrix_mac_engine #(
    parameter int unsigned ACC_W = 10
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       data_w1,
    input  logic [3:0]       data_w2,
    input  logic [3:0]       data_w3,
    input  logic [3:0]       data_x1,
    input  logic [3:0]       data_x2,
    input  logic [3:0]       data_x3,
    output logic             unload1,
    output logic             unload2,
    output logic             unload3,
    output logic [ACC_W-1:0] result,
    output logic [3:0]       result_idx,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned PROD_W = 8;
    localparam int unsigned N_DIM  = 3;
    localparam int unsigned N_EL   = 9;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic [2:0] {IDLE, ACC1, ACC2, ACC3, DRAIN, DONE} state_t;

    state_t           state, state_d;
    logic             start_q;
    logic             trigger;
    logic [ACC_W-1:0] acc   [N_EL];
    logic [ACC_W-1:0] acc_d [N_EL];
    logic [IDX_W-1:0] idx, idx_d;
    logic [OP_W-1:0]  w_op  [N_DIM];
    logic [OP_W-1:0]  x_op  [N_DIM];

    logic             unload1_d, unload2_d, unload3_d;
    logic [ACC_W-1:0] result_d;
    logic [3:0]       result_idx_d;
    logic             result_valid_d, busy_d, done_d;

    assign w_op[0] = data_w1;
    assign w_op[1] = data_w2;
    assign w_op[2] = data_w3;
    assign x_op[0] = data_x1;
    assign x_op[1] = data_x2;
    assign x_op[2] = data_x3;

    assign trigger = start & ~start_q;

    // One partial product, extended to accumulator width.
    function automatic logic [ACC_W-1:0] product(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
`ifdef MAC_SIGNED_EN
        logic signed [PROD_W-1:0] sa, sb, p;
        sa = PROD_W'($signed(a));
        sb = PROD_W'($signed(b));
        p  = sa * sb;
        return ACC_W'(p);
`else
        logic [PROD_W-1:0] p;
        p = PROD_W'(a) * PROD_W'(b);
        return ACC_W'(p);
`endif
    endfunction

    // Next state, accumulator update and next registered outputs.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        for (int k = 0; k < N_EL; k++) acc_d[k] = acc[k];

        case (state)
            IDLE: begin
                if (trigger) begin
                    state_d = ACC1;
                    idx_d   = '0;
                    for (int k = 0; k < N_EL; k++) acc_d[k] = '0;
                end
            end
            ACC1:  state_d = ACC2;
            ACC2:  state_d = ACC3;
            ACC3:  state_d = DRAIN;
            DRAIN: begin
                if (result_ready) begin
                    if (idx == IDX_W'(N_EL - 1)) state_d = DONE;
                    else                         idx_d   = idx + IDX_W'(1);
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        if (state == ACC1 || state == ACC2 || state == ACC3) begin
            for (int i = 0; i < N_DIM; i++) begin
                for (int j = 0; j < N_DIM; j++) begin
                    acc_d[N_DIM*i + j] = acc[N_DIM*i + j] + product(w_op[i], x_op[j]);
                end
            end
        end

        unload1_d      = (state_d == ACC1);
        unload2_d      = (state_d == ACC2);
        unload3_d      = (state_d == ACC3);
        result_valid_d = (state_d == DRAIN);
        busy_d         = (state_d != IDLE) && (state_d != DONE);
        done_d         = (state_d == DONE);
        result_idx_d   = result_valid_d ? idx_d : '0;
        result_d       = result_valid_d ? acc_d[idx_d] : '0;
    end

    // State, accumulators and registered outputs; clear overrides everything.
    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            idx          <= '0;
            for (int k = 0; k < N_EL; k++) acc[k] <= '0;
            unload1      <= 1'b0;
            unload2      <= 1'b0;
            unload3      <= 1'b0;
            result       <= '0;
            result_idx   <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            start_q      <= start;
            idx          <= idx_d;
            for (int k = 0; k < N_EL; k++) acc[k] <= acc_d[k];
            unload1      <= unload1_d;
            unload2      <= unload2_d;
            unload3      <= unload3_d;
            result       <= result_d;
            result_idx   <= result_idx_d;
            result_valid <= result_valid_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed bench for matrix_mac_engine: table of W/X/C vectors plus clear, backpressure and retrigger sequences.
`timescale 1ns/1ps
module tb_matrix_mac_engine;

    localparam int unsigned ACC_W = 10;

    logic             clk = 1'b0;
    logic             clear, start, result_ready;
    logic [3:0]       data_w1, data_w2, data_w3, data_x1, data_x2, data_x3;
    logic             unload1, unload2, unload3;
    logic [ACC_W-1:0] result;
    logic [3:0]       result_idx;
    logic             result_valid, busy, done;

    matrix_mac_engine #(.ACC_W(ACC_W)) dut (
        .clk(clk), .clear(clear), .start(start),
        .data_w1(data_w1), .data_w2(data_w2), .data_w3(data_w3),
        .data_x1(data_x1), .data_x2(data_x2), .data_x3(data_x3),
        .unload1(unload1), .unload2(unload2), .unload3(unload3),
        .result(result), .result_idx(result_idx), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [35:0] w;   // W row-major, element e at [4e +: 4]
        logic [35:0] x;   // X row-major
        logic [89:0] c;   // expected C row-major, element e at [10e +: 10]
    } vec_t;

    vec_t        vecs [5];
    logic [35:0] cur_w, cur_x;
    int          checks = 0;
    int          failures = 0;

    // Memory bank model: column k of W and row k of X for the asserted unload.
    always_comb begin
        int k;
        k = unload1 ? 0 : unload2 ? 1 : unload3 ? 2 : -1;
        {data_w1, data_w2, data_w3, data_x1, data_x2, data_x3} = '0;
        if (k >= 0) begin
            data_w1 = cur_w[4*(0 + k) +: 4];
            data_w2 = cur_w[4*(3 + k) +: 4];
            data_w3 = cur_w[4*(6 + k) +: 4];
            data_x1 = cur_x[4*(3*k + 0) +: 4];
            data_x2 = cur_x[4*(3*k + 1) +: 4];
            data_x3 = cur_x[4*(3*k + 2) +: 4];
        end
    end

    function automatic logic [35:0] m4(input logic [3:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [89:0] m10(input logic [9:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered right after the edge into ACC1; follows the run through DONE.
    task automatic check_run(input int v, input bit toggle, input bit restart_pulse);
        int cnt;
        string tag;
        cnt = 0;
        tag = $sformatf("v%0d", v);
        if (restart_pulse) start = 1'b0;
        chk({tag, "_acc1_unload"}, {29'd0, unload1, unload2, unload3}, 32'b100);
        chk({tag, "_acc1_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_acc1_valid"}, {31'd0, result_valid}, 32'd0);
        step();
        chk({tag, "_acc2_unload"}, {29'd0, unload1, unload2, unload3}, 32'b010);
        step();
        chk({tag, "_acc3_unload"}, {29'd0, unload1, unload2, unload3}, 32'b001);
        step();
        for (int cyc = 0; cyc < 40 && cnt < 9; cyc++) begin
            if (!toggle)
                chk($sformatf("%s_valid_c%0d", tag, cyc), {31'd0, result_valid}, 32'd1);
            if (result_valid) begin
                chk($sformatf("%s_idx_c%0d", tag, cyc), {28'd0, result_idx}, cnt);
                chk($sformatf("%s_res%0d_c%0d", tag, cnt, cyc), {22'd0, result},
                    {22'd0, vecs[v].c[10*cnt +: 10]});
                chk($sformatf("%s_drain_unload_c%0d", tag, cyc), {29'd0, unload1, unload2, unload3}, 0);
            end
            result_ready = toggle ? cyc[0] : 1'b1;
            if (result_valid && result_ready) cnt++;
            if (restart_pulse && cyc == 3) start = 1'b1;
            step();
        end
        result_ready = 1'b1;
        chk({tag, "_accepted"}, cnt, 9);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_done_valid"}, {31'd0, result_valid}, 32'd0);
        chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_clear();
        start = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
    endtask

    initial begin
        // A: identity x 1..9
        vecs[0].w = m4(1, 0, 0, 0, 1, 0, 0, 0, 1);
        vecs[0].x = m4(1, 2, 3, 4, 5, 6, 7, 8, 9);
        // B: all 15 x all 15
        vecs[1].w = {9{4'hF}};
        vecs[1].x = {9{4'hF}};
        // C: all 15 x all 1
        vecs[2].w = {9{4'hF}};
        vecs[2].x = {9{4'h1}};
`ifdef MAC_SIGNED_EN
        vecs[0].c = m10(1, 2, 3, 4, 5, 6, 7, 10'h3F8, 10'h3F9);
        vecs[1].c = {9{10'd3}};
        vecs[2].c = {9{10'h3FD}};
`else
        vecs[0].c = m10(1, 2, 3, 4, 5, 6, 7, 8, 9);
        vecs[1].c = {9{10'h2A3}};
        vecs[2].c = {9{10'd45}};
`endif
        // D: mixed small values
        vecs[3].w = m4(1, 2, 3, 0, 1, 0, 2, 0, 1);
        vecs[3].x = m4(1, 0, 2, 3, 1, 0, 0, 2, 1);
        vecs[3].c = m10(7, 8, 5, 3, 1, 0, 2, 2, 5);
        // E: all 7 x all 7
        vecs[4].w = {9{4'h7}};
        vecs[4].x = {9{4'h7}};
        vecs[4].c = {9{10'd147}};

        clear = 1'b1;
        start = 1'b0;
        result_ready = 1'b1;
        cur_w = '0;
        cur_x = '0;
        step();
        step();
        chk("rst_unload", {29'd0, unload1, unload2, unload3}, 0);
        chk("rst_result", {22'd0, result}, 0);
        chk("rst_idx", {28'd0, result_idx}, 0);
        chk("rst_valid", {31'd0, result_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        clear = 1'b0;
        step();
        chk("idle_no_start", {31'd0, busy}, 0);

        // Table: back-to-back latency and values with ready held high.
        for (int v = 0; v < 5; v++) begin
            cur_w = vecs[v].w;
            cur_x = vecs[v].x;
            start = 1'b1;
            step();
            check_run(v, 1'b0, 1'b0);
            do_clear();
        end

        // Backpressure: ready alternates during DRAIN.
        cur_w = vecs[3].w;
        cur_x = vecs[3].x;
        start = 1'b1;
        step();
        check_run(3, 1'b1, 1'b0);
        do_clear();

        // Clear in ACC2 with start held: abort, then retrigger.
        cur_w = vecs[4].w;
        cur_x = vecs[4].x;
        start = 1'b1;
        step();
        step();
        chk("abort_in_acc2", {29'd0, unload1, unload2, unload3}, 32'b010);
        clear = 1'b1;
        step();
        chk("abort_unload", {29'd0, unload1, unload2, unload3}, 0);
        chk("abort_valid", {31'd0, result_valid}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        clear = 1'b0;
        step();
        check_run(4, 1'b0, 1'b0);
        do_clear();

        // Start edges during DRAIN and DONE are ignored.
        cur_w = vecs[2].w;
        cur_x = vecs[2].x;
        start = 1'b1;
        step();
        check_run(2, 1'b0, 1'b1);
        start = 1'b0;
        step();
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("done_hold_%0d", i), {28'd0, done, result_valid, busy, unload1}, 32'b1000);
        end
        do_clear();
        chk("final_idle", {28'd0, done, result_valid, busy, unload1}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
